// File: rtl/i2s_mic_ctrl_if.sv
// i2s_mic_ctrl_if: sample read port of the I2S microphone controller.
// Optional macro I2S_MIC_CTRL_STEREO_EN adds rd_chan alongside rd_data.
//
// Handshake: rd_valid is high while the FIFO holds at least one sample.
// rd_data (and rd_chan) show the head entry whenever rd_valid is high.
// The head is consumed on a rising HCLK edge where rd_valid && rd_ready.
// rd_ready may be high while rd_valid is low; nothing is consumed then.
// rd_valid never depends on rd_ready.
interface i2s_mic_ctrl_if #(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8
);
    logic [SAMPLE_W-1:0]           rd_data;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [$clog2(FIFO_DEPTH):0]   level;
`ifdef I2S_MIC_CTRL_STEREO_EN
    logic                          rd_chan;

    modport master (output rd_data, rd_valid, rd_chan, level, input rd_ready);
    modport slave  (input rd_data, rd_valid, rd_chan, level, output rd_ready);
`else
    modport master (output rd_data, rd_valid, level, input rd_ready);
    modport slave  (input rd_data, rd_valid, level, output rd_ready);
`endif
endinterface

// File: rtl/i2s_mic_ctrl.sv
// i2s_mic_ctrl: I2S master receive controller.
// Generates i2s_clk/ws from HCLK, captures one slot per frame (MSB first,
// one-bit I2S delay), queues samples in a show-ahead FIFO read through
// i2s_mic_ctrl_if. Start-up discards one warm-up frame; stop completes the
// current frame before returning to IDLE.
// Optional macro I2S_MIC_CTRL_STEREO_EN: capture both slots and store the
// slot id with each sample (rd_chan, 0 = left).
module i2s_mic_ctrl #(
    parameter int CLK_DIV_W  = 8,
    parameter int SAMPLE_W   = 24,
    parameter int FRAME_BITS = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 en,
    input  logic [CLK_DIV_W-1:0] clk_div,
    input  logic                 chan_sel,
    input  logic                 i2s_sd,
    output logic                 i2s_clk,
    output logic                 ws,
    output logic                 overflow,
    input  logic                 ovf_clr,
    output logic                 busy,
    output logic [1:0]           state_dbg,
    i2s_mic_ctrl_if.master       rd_if
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(2 * FRAME_BITS);
`ifdef I2S_MIC_CTRL_STEREO_EN
    localparam int ENTRY_W = SAMPLE_W + 1;
`else
    localparam int ENTRY_W = SAMPLE_W;
`endif

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF  = BIT_W'(FRAME_BITS);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(SAMPLE_W);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Sequencer / clock generator / capture state
    state_t                 state_q, state_d;
    logic [CLK_DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CLK_DIV_W-1:0]   clk_div_q, clk_div_d;
    logic                   chan_sel_q, chan_sel_d;
    logic                   i2s_clk_q, i2s_clk_d;
    logic                   ws_q, ws_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]    shift_q, shift_d;
    logic                   push_q, push_d;
`ifdef I2S_MIC_CTRL_STEREO_EN
    logic                   push_chan_q, push_chan_d;
`endif

    // FIFO state
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;

    // Combinational helpers
    logic                   tick;
    logic                   fall;
    logic                   rise;
    logic                   wrap;
    logic                   capture_slot;
    logic                   capturing;
    logic [BIT_W-1:0]       slot_idx;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   push_ok;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head;
    logic                   valid;

    // Next-state: divider, bit counter, ws, capture shifter and FSM
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        clk_div_d  = clk_div_q;
        chan_sel_d = chan_sel_q;
        i2s_clk_d  = i2s_clk_q;
        ws_d       = ws_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
`ifdef I2S_MIC_CTRL_STEREO_EN
        push_chan_d = push_chan_q;
`endif
        tick = (div_cnt_q == clk_div_q);
        fall = 1'b0;
        rise = 1'b0;
        wrap = 1'b0;
        slot_idx = (bit_cnt_q >= BIT_HALF) ? (bit_cnt_q - BIT_HALF) : bit_cnt_q;

        // Divider runs in every state except IDLE
        if (state_q != ST_IDLE) begin
            if (tick) begin
                div_cnt_d = '0;
                i2s_clk_d = ~i2s_clk_q;
                fall      = i2s_clk_q;
                rise      = ~i2s_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        // Bit position and ws advance only on the falling i2s_clk toggle
        if (fall) begin
            wrap      = (bit_cnt_q == BIT_LAST);
            bit_cnt_d = wrap ? '0 : (bit_cnt_q + 1'b1);
            ws_d      = (bit_cnt_d >= BIT_HALF);
        end

`ifdef I2S_MIC_CTRL_STEREO_EN
        capture_slot = 1'b1;
`else
        capture_slot = (ws_q == chan_sel_q);
`endif
        capturing = (state_q == ST_RUN) || (state_q == ST_STOP);

        // Slot index 0 is the I2S delay bit; 1..SAMPLE_W carry the sample
        if (rise && capturing && capture_slot &&
            (slot_idx != '0) && (slot_idx <= IDX_LAST)) begin
            shift_d = {shift_q[SAMPLE_W-2:0], i2s_sd};
            if (slot_idx == IDX_LAST) begin
                push_d = 1'b1;
`ifdef I2S_MIC_CTRL_STEREO_EN
                push_chan_d = ws_q;
`endif
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_WARMUP;
                    clk_div_d  = clk_div;
                    chan_sel_d = chan_sel;
                end
            end
            ST_WARMUP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // en is deliberately not looked at: the frame always completes
                if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering or staying in IDLE parks the bus with everything at zero
        if (state_d == ST_IDLE) begin
            div_cnt_d = '0;
            i2s_clk_d = 1'b0;
            ws_d      = 1'b0;
            bit_cnt_d = '0;
        end
    end

    // Sequencer registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            clk_div_q  <= '0;
            chan_sel_q <= 1'b0;
            i2s_clk_q  <= 1'b0;
            ws_q       <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
`ifdef I2S_MIC_CTRL_STEREO_EN
            push_chan_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            clk_div_q  <= clk_div_d;
            chan_sel_q <= chan_sel_d;
            i2s_clk_q  <= i2s_clk_d;
            ws_q       <= ws_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
`ifdef I2S_MIC_CTRL_STEREO_EN
            push_chan_q <= push_chan_d;
`endif
        end
    end

`ifdef I2S_MIC_CTRL_STEREO_EN
    assign push_entry = {push_chan_q, shift_q};
`else
    assign push_entry = shift_q;
`endif

    // FIFO next-state: a push into a full FIFO survives only with a pop
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        fifo_pop  = (count_q != '0) && rd_if.rd_ready;
        fifo_full = (count_q == LVL_FULL);
        push_ok   = push_q && (!fifo_full || fifo_pop);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push_q && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO registers; contents survive IDLE and are flushed only by reset
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);

    assign rd_if.rd_valid = valid;
    assign rd_if.rd_data  = valid ? head[SAMPLE_W-1:0] : '0;
    assign rd_if.level    = count_q;
`ifdef I2S_MIC_CTRL_STEREO_EN
    assign rd_if.rd_chan  = valid ? head[ENTRY_W-1] : 1'b0;
`endif

    assign i2s_clk   = i2s_clk_q;
    assign ws        = ws_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2s_mic_ctrl.sv
// tb_i2s_mic_ctrl: directed bench for i2s_mic_ctrl (default mono build).
// A microphone model sends left = A5C3F1 + 010101*(f-1) in frame f (frame 0
// is the warm-up frame and carries a sentinel), right = 123456 every frame.
`timescale 1ns/1ps
module tb_i2s_mic_ctrl;

    localparam int CLK_DIV_W  = 8;
    localparam int SAMPLE_W   = 24;
    localparam int FRAME_BITS = 32;
    localparam int FIFO_DEPTH = 8;
    localparam logic [23:0] RIGHT_WORD = 24'h123456;

    // Clock / reset and plain DUT inputs
    logic                 HCLK    = 1'b0;
    logic                 HRESET  = 1'b0;
    logic                 en      = 1'b0;
    logic [CLK_DIV_W-1:0] clk_div = '0;
    logic                 chan_sel = 1'b0;
    logic                 i2s_sd  = 1'b0;
    logic                 ovf_clr = 1'b0;

    logic                 i2s_clk;
    logic                 ws;
    logic                 overflow;
    logic                 busy;
    logic [1:0]           state_dbg;

    i2s_mic_ctrl_if #(.SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) rd_if ();

    int vectors     = 0;
    int miscompares = 0;

    // Microphone model state
    int   pos     = 0;
    int   frame   = 0;
    logic prev_ws = 1'b0;

    always #5 HCLK = ~HCLK;

    i2s_mic_ctrl #(
        .CLK_DIV_W (CLK_DIV_W),
        .SAMPLE_W  (SAMPLE_W),
        .FRAME_BITS(FRAME_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .en       (en),
        .clk_div  (clk_div),
        .chan_sel (chan_sel),
        .i2s_sd   (i2s_sd),
        .i2s_clk  (i2s_clk),
        .ws       (ws),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .busy     (busy),
        .state_dbg(state_dbg),
        .rd_if    (rd_if)
    );

    function automatic logic [23:0] left_word(input int f);
        if (f == 0) return 24'h5A5A5A;
        return 24'hA5C3F1 + 24'h010101 * 24'(f - 1);
    endfunction

    // Microphone: changes sd after each falling i2s_clk, MSB one bit after ws
    always @(negedge i2s_clk) begin
        logic [23:0] w;
        #1;
        if (busy !== 1'b1 || HRESET) begin
            pos   = 0;
            frame = 0;
        end else if (ws !== prev_ws) begin
            pos = 0;
            if (ws == 1'b0) frame++;
        end else begin
            pos++;
        end
        prev_ws = ws;
        w = ws ? RIGHT_WORD : left_word(frame);
        i2s_sd = (pos >= 1 && pos <= SAMPLE_W) ? w[SAMPLE_W - pos] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic pop_one();
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic wait_rise(output int cyc);
        logic p;
        p   = i2s_clk;
        cyc = 0;
        while (cyc < 2000) begin
            step();
            cyc++;
            if (!p && i2s_clk) break;
            p = i2s_clk;
        end
    endtask

    task automatic wait_ws_change(output int cyc);
        logic p;
        p   = ws;
        cyc = 0;
        while (cyc < 2000) begin
            step();
            cyc++;
            if (p !== ws) break;
        end
    endtask

    initial begin
        int c;
        int n;
        int f;
        int falls;
        logic p;
        logic [23:0] saved;

        rd_if.rd_ready = 1'b0;
        #1 HRESET = 1'b1;
        step();
        step();
        check("rst_i2s_clk", i2s_clk, 0);
        check("rst_ws", ws, 0);
        check("rst_rd_valid", rd_if.rd_valid, 0);
        check("rst_level", rd_if.level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_if.rd_data, 0);
        HRESET = 1'b0;
        step();

        // Start with clk_div=3; later input changes must be ignored
        clk_div  = 8'd3;
        chan_sel = 1'b0;
        en       = 1'b1;
        step();
        check("busy_on", busy, 1);
        check("state_warmup", state_dbg, 1);
        clk_div  = 8'd9;
        chan_sel = 1'b1;
        wait_rise(c);
        wait_rise(c);
        check("clk_period", c, 8);

        wait_ws_change(c);
        check("ws_first_high", ws, 1);
        check("ws_rise_on_fall", i2s_clk, 0);
        wait_ws_change(c);
        check("ws_half_frame", c, 256);
        check("ws_fall_on_fall", i2s_clk, 0);

        // First captured sample comes from frame 1, left slot
        n = 0;
        while (!rd_if.rd_valid && n < 700) begin step(); n++; end
        check("first_valid_to", n < 700, 1);
        check("first_sample", rd_if.rd_data, 24'hA5C3F1);
        check("level_one", rd_if.level, 1);
        check("state_run", state_dbg, 2);

        // Fill to full, then one more capture is dropped
        n = 0;
        while (rd_if.level != 8 && n < 5000) begin step(); n++; end
        check("fill_to", n < 5000, 1);
        check("ovf_before_drop", overflow, 0);
        n = 0;
        while (!overflow && n < 700) begin step(); n++; end
        check("ovf_set", overflow, 1);
        check("level_full", rd_if.level, 8);
        for (int k = 0; k < 8; k++) begin
            check("pop_data", rd_if.rd_data, left_word(1 + k));
            pop_one();
        end
        check("level_drained", rd_if.level, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Full FIFO: pop in the exact cycle of the next push
        n = 0;
        while (rd_if.level != 8 && n < 5000) begin step(); n++; end
        check("refill_to", n < 5000, 1);
        p = i2s_clk;
        n = 0;
        while (n < 700) begin
            step();
            n++;
            if (!p && i2s_clk && ws == 1'b0 && pos == 24) break;
            p = i2s_clk;
        end
        check("push_edge_to", n < 700, 1);
        check("full_before_pushpop", rd_if.level, 8);
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_ready = 1'b0;
        check("pushpop_level", rd_if.level, 8);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_head", rd_if.rd_data, left_word(frame - 7));

        // Align to a frame start, drain, then stop at bit_cnt 40
        p = ws;
        n = 0;
        while (!(p && !ws) && n < 700) begin p = ws; step(); n++; end
        check("frame_start_to", n < 700, 1);
        n = 0;
        while (rd_if.rd_valid && n < 20) begin
            check("no_right_word", rd_if.rd_data == RIGHT_WORD, 0);
            pop_one();
            n++;
        end
        check("drained", rd_if.level, 0);
        n = 0;
        while (!(ws == 1'b1 && pos == 8) && n < 700) begin step(); n++; end
        check("bit40_to", n < 700, 1);
        f     = frame;
        saved = left_word(f);
        check("stop_level", rd_if.level, 1);
        check("stop_head", rd_if.rd_data, saved);
        en    = 1'b0;
        p     = i2s_clk;
        falls = 0;
        n     = 0;
        while (busy && n < 600) begin
            step();
            n++;
            if (p && !i2s_clk) falls++;
            p = i2s_clk;
        end
        check("stop_to", n < 600, 1);
        check("stop_falls", falls, 24);
        check("idle_clk", i2s_clk, 0);
        check("idle_ws", ws, 0);
        check("idle_state", state_dbg, 0);
        check("no_extra_push", rd_if.level, 1);
        check("persist_head", rd_if.rd_data, saved);

        // Abort during warm-up forces i2s_clk low at once
        clk_div  = 8'd1;
        chan_sel = 1'b0;
        en       = 1'b1;
        step();
        step();
        step();
        check("abort_pre_clk", i2s_clk, 1);
        en = 1'b0;
        step();
        check("abort_busy", busy, 0);
        check("abort_clk", i2s_clk, 0);
        check("abort_level", rd_if.level, 1);

        // Fastest divider, then overflow with the old head still in front
        clk_div = 8'd0;
        en      = 1'b1;
        step();
        wait_rise(c);
        wait_rise(c);
        check("div0_period", c, 2);
        n = 0;
        while (!overflow && n < 2500) begin step(); n++; end
        check("div0_ovf", overflow, 1);
        check("div0_level", rd_if.level, 8);
        check("div0_head", rd_if.rd_data, saved);

        // Asynchronous reset in the middle of a frame
        step();
        #2 HRESET = 1'b1;
        #1;
        check("mid_rst_i2s_clk", i2s_clk, 0);
        check("mid_rst_ws", ws, 0);
        check("mid_rst_rd_valid", rd_if.rd_valid, 0);
        check("mid_rst_level", rd_if.level, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_data", rd_if.rd_data, 0);
        en = 1'b0;
        step();
        HRESET = 1'b0;
        step();
        check("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
